pipelined_sel_multiplier: RTL

- Next-generation operand-select multiplier: picks one of CHANNELS operand pairs by index and multiplies them.
- Sits on the datapath between operand-producing stages and the result consumer.
- Generalises the 2:1 select / 8x8 unsigned form to:
  - parametrised width and channel count;
  - runtime signed/unsigned mode;
  - a STAGES-deep pipeline with valid/ready backpressure.
- Result is always full width (2*WIDTH); no truncation.

---
 rtl/mul_pkg.sv | 40 ++++
 rtl/mul_pipe_stage.sv | 31 +++
 rtl/pipelined_sel_multiplier.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for pipelined_sel_multiplier.
// Optional accumulate mode is enabled by defining MUL_ACC_EN.
package mul_pkg;

   // Widest operand / result the extension helper handles.
   localparam int unsigned EXT_IN_W    = 64;
   localparam int unsigned EXT_OUT_W   = 128;
   // Guard bits added above the product for the accumulator.
   localparam int unsigned ACC_GUARD_W = 8;

   // Per-item side-band flags carried down the pipeline next to the product.
   typedef struct packed {
      logic sel_err;
`ifdef MUL_ACC_EN
      logic acc_en;
      logic acc_clr;
      logic is_signed;
`endif
   } stage_flags_t;

   // Sign- or zero-extend the low w bits of value to EXT_OUT_W bits.
   function automatic logic [EXT_OUT_W-1:0] sext_zext(input logic [EXT_IN_W-1:0] value,
                                                      input int unsigned         w,
                                                      input logic                is_signed);
      logic                 fill;
      logic [EXT_OUT_W-1:0] result;
      fill   = 1'b0;
      result = '0;
      for (int unsigned i = 0; i < EXT_IN_W; i++) begin
         if (i + 1 == w) begin
            fill = is_signed & value[i[5:0]];
         end
      end
      for (int unsigned i = 0; i < EXT_OUT_W; i++) begin
         result[i] = (i < w) ? value[i[5:0]] : fill;
      end
      return result;
   endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One holdable pipeline slot: valid bit plus payload, loaded when en_i is high.
module mul_pipe_stage #(
   parameter type payload_t = logic
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en_i,
   input  logic     valid_i,
   input  payload_t payload_i,
   output logic     valid_o,
   output payload_t payload_o
);

   logic     valid_q;
   payload_t payload_q;

   // Slot register: shift in when the pipeline advances, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else if (en_i) begin
         valid_q   <= valid_i;
         payload_q <= payload_i;
      end
   end

   assign valid_o   = valid_q;
   assign payload_o = payload_q;

endmodule

// File: rtl/pipelined_sel_multiplier.sv
// Operand-select multiplier: picks one of CHANNELS operand pairs, multiplies
// them (signed or unsigned per item) and delivers a full-width product after
// STAGES register stages with valid/ready backpressure.
// Defining MUL_ACC_EN adds an accumulator on retiring products (acc_en/acc_clr/acc_out).
module pipelined_sel_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned STAGES   = 2,
   parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] a_bus,
   input  logic [CHANNELS*WIDTH-1:0] b_bus,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      is_signed,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*WIDTH-1:0]        product,
   output logic                      sel_err
`ifdef MUL_ACC_EN
   ,
   input  logic                      acc_en,
   input  logic                      acc_clr,
   output logic [2*WIDTH+ACC_GUARD_W-1:0] acc_out
`endif
);

   localparam int unsigned PROD_W = 2 * WIDTH;

   typedef struct packed {
      logic [PROD_W-1:0] product;
      stage_flags_t      flags;
   } payload_t;

   logic              advance;
   logic [WIDTH-1:0]  a_sel;
   logic [WIDTH-1:0]  b_sel;
   logic [PROD_W-1:0] a_ext;
   logic [PROD_W-1:0] b_ext;
   logic              sel_bad;
   payload_t          stage_in_d;

   logic [STAGES-1:0] valid_q;
   payload_t          pay_q [STAGES];

   // Whole pipeline moves when the output slot is empty or being consumed.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Operand mux, extension and multiply feeding stage 0.
   always_comb begin
      a_sel      = '0;
      b_sel      = '0;
      stage_in_d = '0;
      sel_bad    = (32'(sel) >= CHANNELS);
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (32'(sel) == i) begin
            a_sel = a_bus[i*WIDTH +: WIDTH];
            b_sel = b_bus[i*WIDTH +: WIDTH];
         end
      end
      a_ext = PROD_W'(sext_zext(EXT_IN_W'(a_sel), WIDTH, is_signed));
      b_ext = PROD_W'(sext_zext(EXT_IN_W'(b_sel), WIDTH, is_signed));
      stage_in_d.product       = sel_bad ? '0 : a_ext * b_ext;
      stage_in_d.flags.sel_err = sel_bad;
`ifdef MUL_ACC_EN
      stage_in_d.flags.acc_en    = acc_en;
      stage_in_d.flags.acc_clr   = acc_clr;
      stage_in_d.flags.is_signed = is_signed;
`endif
   end

   // Chain of STAGES holdable slots, all enabled by advance.
   for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
      if (g == 0) begin : g_first
         mul_pipe_stage #(.payload_t(payload_t)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (advance),
            .valid_i   (in_valid),
            .payload_i (stage_in_d),
            .valid_o   (valid_q[g]),
            .payload_o (pay_q[g])
         );
      end else begin : g_rest
         mul_pipe_stage #(.payload_t(payload_t)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      (advance),
            .valid_i   (valid_q[g-1]),
            .payload_i (pay_q[g-1]),
            .valid_o   (valid_q[g]),
            .payload_o (pay_q[g])
         );
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign product   = pay_q[STAGES-1].product;
   assign sel_err   = pay_q[STAGES-1].flags.sel_err;

`ifdef MUL_ACC_EN
   localparam int unsigned ACC_W = PROD_W + ACC_GUARD_W;

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] prod_ext;

   // Accumulator update on each retiring item; clear wins over add.
   always_comb begin
      acc_d    = acc_q;
      prod_ext = ACC_W'(sext_zext(EXT_IN_W'(product), PROD_W,
                                  pay_q[STAGES-1].flags.is_signed));
      if (out_valid && out_ready) begin
         if (pay_q[STAGES-1].flags.acc_clr) begin
            acc_d = prod_ext;
         end else if (pay_q[STAGES-1].flags.acc_en) begin
            acc_d = acc_q + prod_ext;
         end
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_out = acc_q;
`endif

endmodule
